// File: rtl/sub_byte_sched.sv
// Shares one 32-bit S-box slice between state SubBytes (4 cycles) and key SubWord (1 cycle).
// Latency grant->done: state 5, key 2; requesters hold req until done, job-level round-robin.
module sub_byte_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_req,
  input  logic [0:127] st_in,
  output logic         st_done,
  output logic [0:127] st_out,
  input  logic         kw_req,
  input  logic [0:31]  kw_in,
  output logic         kw_done,
  output logic [0:31]  kw_out,
  output logic [0:31]  sb_in,
  input  logic [0:31]  sb_out,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ST_RUN  = 3'd1,
    KW_RUN  = 3'd2,
    ST_DONE = 3'd3,
    KW_DONE = 3'd4
  } state_t;

  state_t       state, state_nxt;
  logic [1:0]   wc, wc_nxt;
  logic         last_kw, last_kw_nxt;
  logic         grant_st, grant_kw;
  logic [0:127] cap;

  always_comb begin
    state_nxt   = state;
    wc_nxt      = wc;
    last_kw_nxt = last_kw;
    grant_st    = 1'b0;
    grant_kw    = 1'b0;
    sb_in       = '0;
    st_done     = 1'b0;
    kw_done     = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the class that did not run last wins.
        grant_kw = kw_req && (!st_req || !last_kw);
        grant_st = st_req && !grant_kw;
        if (grant_kw) begin
          state_nxt = KW_RUN;
        end else if (grant_st) begin
          state_nxt = ST_RUN;
          wc_nxt    = 2'd0;
        end
      end
      ST_RUN: begin
        sb_in  = cap[{wc, 5'd0} +: 32];
        wc_nxt = wc + 2'd1;
        if (wc == 2'd3) begin
          state_nxt = ST_DONE;
        end
      end
      KW_RUN: begin
        sb_in     = cap[0:31];
        state_nxt = KW_DONE;
      end
      ST_DONE: begin
        st_done     = 1'b1;
        last_kw_nxt = 1'b0;
        state_nxt   = IDLE;
      end
      KW_DONE: begin
        kw_done     = 1'b1;
        last_kw_nxt = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wc      <= 2'd0;
      last_kw <= 1'b0;
      cap     <= '0;
      st_out  <= '0;
      kw_out  <= '0;
    end else begin
      state   <= state_nxt;
      wc      <= wc_nxt;
      last_kw <= last_kw_nxt;
      if (grant_st) begin
        cap <= st_in;
      end else if (grant_kw) begin
        cap[0:31] <= kw_in;
      end
      if (state == ST_RUN) begin
        st_out[{wc, 5'd0} +: 32] <= sb_out;
      end
      if (state == KW_RUN) begin
        kw_out <= sb_out;
      end
    end
  end

endmodule
